// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM receive path.
package tdm_pkg;
  localparam int LANES  = 8;
  localparam int SLOT_W = 3;

  typedef logic [LANES-1:0] frame_t;
endpackage

// File: rtl/demux_1to8.sv
// 1:8 write-enable demux built as a tree of 1:2 cells (s[2], then s[1], then s[0]),
// the mirror image of the 8:1 mux tree on the transmit side.
module demux_1to8
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0] i_cnt,
  input  logic              i_valid,
  output logic [LANES-1:0]  o_en
);

  logic [1:0] w_l1;
  logic [3:0] w_l2;

  // top cell splits on s[2]
  assign w_l1[0] = i_valid & ~i_cnt[2];
  assign w_l1[1] = i_valid &  i_cnt[2];

  genvar j;
  generate
    // middle cells split on s[1]
    for (j = 0; j < 2; j++) begin : g_l2
      assign w_l2[2*j]   = w_l1[j] & ~i_cnt[1];
      assign w_l2[2*j+1] = w_l1[j] &  i_cnt[1];
    end
    // leaf cells split on s[0]
    for (j = 0; j < 4; j++) begin : g_l3
      assign o_en[2*j]   = w_l2[j] & ~i_cnt[0];
      assign o_en[2*j+1] = w_l2[j] &  i_cnt[0];
    end
  endgenerate

endmodule

// File: rtl/tdm_demux8.sv
// Serial-to-parallel 1:8 TDM demux: steers each valid bit into the slot picked by
// the slot counter and hands complete frames out on a valid/ready byte port.
module tdm_demux8
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [LANES-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [SLOT_W-1:0] slot,
  output logic              ovf,
  input  logic              ovf_clr
);

  logic [SLOT_W-1:0] r_cnt;
  logic [LANES-2:0]  r_sh;
  frame_t            r_dout;
  logic              r_valid;
  logic              r_ovf;

  logic              w_adv;
  logic [LANES-1:0]  w_en;
  logic              w_complete;
  logic              w_load;
  logic              w_drop;

  // a sync bit restarts the frame rather than advancing it, so it never fires the demux
  assign w_adv = din_valid & ~sync;

  demux_1to8 u_demux (
    .i_cnt   (r_cnt),
    .i_valid (w_adv),
    .o_en    (w_en)
  );

  // slot-7 bit closes a frame; load if the output is free or being taken this edge
  assign w_complete = w_en[LANES-1];
  assign w_load     = w_complete & (~r_valid | dout_ready);
  assign w_drop     = w_complete &   r_valid & ~dout_ready;

  // slot counter: sync forces slot 1 (its own bit took slot 0), else advance and wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_cnt <= '0;
    else if (din_valid) r_cnt <= sync ? SLOT_W'(1) : r_cnt + 1'b1;
  end

  // shadow bits for slots 0..6; stale bits are simply overwritten as a frame refills
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
    end else begin
      for (int i = 0; i < LANES-1; i++)
        if (w_en[i]) r_sh[i] <= din;
      if (din_valid && sync) r_sh[0] <= din;
    end
  end

  // output byte and valid flag; a take and a new frame on one edge leaves no bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_dout  <= {din, r_sh};
      r_valid <= 1'b1;
    end else if (r_valid && dout_ready) begin
      r_valid <= 1'b0;
    end
  end

  // sticky overflow; a drop on the same edge as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign slot       = r_cnt;
  assign ovf        = r_ovf;

endmodule
